// File: rtl/cordic_vectoring_if.sv
// Start/busy/done handshake bundle for the CORDIC vectoring engine.
// Master drives the request, slave returns magnitude and angle.
interface cordic_vectoring_if #(
    parameter int N = 31,
    parameter int M = 31
);
    logic       start;
    logic [N:0] x0;
    logic [N:0] y0;
    logic       busy;
    logic       done;
    logic [N:0] mag;
    logic [M:0] output_angle;

    modport master (
        output start, x0, y0,
        input  busy, done, mag, output_angle
    );
    modport slave (
        input  start, x0, y0,
        output busy, done, mag, output_angle
    );
endinterface

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC vectoring: (x0, y0) in Q12.20 -> magnitude and angle.
// One micro-rotation per clock, start/busy/done handshake.
module cordic_vectoring #(
    parameter int N    = 31,
    parameter int M    = 31,
    parameter int FRAC = 20,
    parameter int ITER = 24
) (
    input  logic              clk,
    input  logic              rst,
    cordic_vectoring_if.slave io
);
    // Extra fraction bits keep shift truncation noise out of the angle.
    localparam int G  = 8;
    localparam int W  = N + 4 + G;
    localparam int ZW = M + 3;
    localparam int AW = M + 4;
    localparam int PW = W + 22;
    localparam int IW = $clog2(ITER);

    localparam logic signed [21:0]   K      = 22'sh09B74F;
    localparam logic signed [AW-1:0] DEG0   = '0;
    localparam logic signed [AW-1:0] DEG180 = AW'(64'd180 << FRAC);
    localparam logic signed [AW-1:0] DEG360 = AW'(64'd360 << FRAC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ITER,
        S_SCALE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic signed [W-1:0]   x_q, x_d;
    logic signed [W-1:0]   y_q, y_d;
    logic signed [ZW-1:0]  z_q, z_d;
    logic [IW-1:0]         i_q, i_d;
    logic                  neg_q, neg_d;
    logic                  zero_q, zero_d;
    logic [N:0]            mag_q, mag_d;
    logic [M:0]            ang_q, ang_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic signed [W-1:0]   dx, dy;
    logic signed [PW-1:0]  prod, sh;
    logic signed [AW-1:0]  a;

    function automatic logic signed [ZW-1:0] atan_lut(
        input logic [IW-1:0] idx
    );
        logic [31:0] v;
        case (int'(idx))
            0:  v = 32'd47185920;
            1:  v = 32'd27855475;
            2:  v = 32'd14718068;
            3:  v = 32'd7471121;
            4:  v = 32'd3750058;
            5:  v = 32'd1876857;
            6:  v = 32'd938658;
            7:  v = 32'd469357;
            8:  v = 32'd234682;
            9:  v = 32'd117342;
            10: v = 32'd58671;
            11: v = 32'd29335;
            12: v = 32'd14668;
            13: v = 32'd7334;
            14: v = 32'd3667;
            15: v = 32'd1833;
            16: v = 32'd917;
            17: v = 32'd458;
            18: v = 32'd229;
            19: v = 32'd115;
            20: v = 32'd57;
            21: v = 32'd29;
            22: v = 32'd14;
            23: v = 32'd7;
            default: v = 32'd0;
        endcase
        return ZW'(v);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            mag_q   <= '0;
            ang_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
            mag_q   <= mag_d;
            ang_q   <= ang_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        neg_d   = neg_q;
        zero_d  = zero_q;
        mag_d   = mag_q;
        ang_d   = ang_q;
        done_d  = 1'b0;
        dx      = y_q >>> i_q;
        dy      = x_q >>> i_q;
        prod    = PW'(x_q) * PW'(K);
        sh      = prod >>> (FRAC + G);
        a       = (neg_q ? DEG180 : DEG0) + AW'(z_q);

        unique case (state_q)
            S_IDLE: begin
                if (io.start) begin
                    x_d     = W'($signed(io.x0)) <<< G;
                    y_d     = W'($signed(io.y0)) <<< G;
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                zero_d = (x_q == '0) && (y_q == '0);
                neg_d  = x_q[W-1];
                if (x_q[W-1]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                end
                z_d     = '0;
                i_d     = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (!y_q[W-1]) begin
                    x_d = x_q + dx;
                    y_d = y_q - dy;
                    z_d = z_q + atan_lut(i_q);
                end else begin
                    x_d = x_q - dx;
                    y_d = y_q + dy;
                    z_d = z_q - atan_lut(i_q);
                end
                i_d = i_q + IW'(1);
                if (i_q == IW'(ITER - 1)) begin
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                if (sh[PW-1]) begin
                    mag_d = '0;
                end else if (|sh[PW-2:N+1]) begin
                    mag_d = '1;
                end else begin
                    mag_d = sh[N:0];
                end
                if (a < DEG0) begin
                    a = a + DEG360;
                end else if (a >= DEG360) begin
                    a = a - DEG360;
                end
                ang_d = a[M:0];
                if (zero_q) begin
                    mag_d = '0;
                    ang_d = '0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign io.busy         = busy_q;
    assign io.done         = done_q;
    assign io.mag          = mag_q;
    assign io.output_angle = ang_q;
endmodule
